// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and instruction-fetch sequencer for a simple
//   multi-cycle RV32 core. Each instruction is fetched from instruction
//   memory and latched. It is then held for decode and execute until
//   the core releases it. A next-PC that is not word aligned traps into
//   HALT, where the unit waits for TRAP_CLR.
//
//   State table
//     state | meaning
//     BOOT  | one idle cycle after reset or trap clear, no request
//     FETCH | IMEM_REQ high at IMEM_ADDR=PC, waiting for IMEM_READY
//     EXEC  | INSTR/PC presented to decode, waiting for STALL=0
//     HALT  | misaligned-target trap pending, waiting for TRAP_CLR
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   PC_Sel          next-PC select (00 seq, 01 branch/JAL, 10 JALR, 11 seq)
//   BRANCH_TARGET   PC+imm target
//   JALR_TARGET     rs1+imm target (bit 0 is cleared)
//   STALL           hold the current instruction in EXEC
//   TRAP_CLR        leave HALT and restart at RESET_VECTOR
//   IMEM_READY      instruction memory read data valid
//   IMEM_RDATA      instruction memory read data
//   IMEM_REQ        fetch request
//   IMEM_ADDR       fetch address
//   INSTR           latched instruction
//   INSTR_VALID     INSTR valid to decode
//   PC              address of INSTR
//   PC_PLUS4        PC+4 link value
//   MISALIGN_TRAP   instruction-address-misaligned trap flag
//   TRAP_ADDR       offending target address
//   RETIRE_CNT      retired-instruction count

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PC_Sel,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] JALR_TARGET,
  input  logic        STALL,
  input  logic        TRAP_CLR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        MISALIGN_TRAP,
  output logic [31:0] TRAP_ADDR,
  output logic [31:0] RETIRE_CNT
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] trap_addr_q;
  logic [31:0] retire_q;
  logic        trap_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // 32-bit add wraps naturally, so 0xFFFF_FFFC + 4 = 0 with no trap.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (PC_Sel)
      2'b01:   next_pc = BRANCH_TARGET;
      2'b10:   next_pc = {JALR_TARGET[31:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

  // IMEM_REQ and INSTR_VALID are registered alongside the state so they
  // are glitch-free and always agree with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      instr_q     <= NOP_INSTR;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= 32'h0000_0000;
      retire_q    <= 32'h0000_0000;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (IMEM_READY) begin
            instr_q <= IMEM_RDATA;
            state   <= S_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!STALL) begin
            valid_q <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc_q     <= next_pc;
              retire_q <= retire_q + 32'd1;
              state    <= S_FETCH;
              req_q    <= 1'b1;
            end else begin
              // Trapping instruction does not retire and PC stays on it.
              trap_q      <= 1'b1;
              trap_addr_q <= next_pc;
              state       <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (TRAP_CLR) begin
            trap_q <= 1'b0;
            pc_q   <= RESET_VECTOR;
            state  <= S_BOOT;
          end
        end
        default: begin
          state   <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ      = req_q;
  assign IMEM_ADDR     = pc_q;
  assign INSTR         = instr_q;
  assign INSTR_VALID   = valid_q;
  assign PC            = pc_q;
  assign PC_PLUS4      = pc_plus4;
  assign MISALIGN_TRAP = trap_q;
  assign TRAP_ADDR     = trap_addr_q;
  assign RETIRE_CNT    = retire_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PC_Sel;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] JALR_TARGET;
  logic        STALL;
  logic        TRAP_CLR;
  logic        IMEM_READY;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        MISALIGN_TRAP;
  logic [31:0] TRAP_ADDR;
  logic [31:0] RETIRE_CNT;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RST(RST), .PC_Sel(PC_Sel),
    .BRANCH_TARGET(BRANCH_TARGET), .JALR_TARGET(JALR_TARGET),
    .STALL(STALL), .TRAP_CLR(TRAP_CLR),
    .IMEM_READY(IMEM_READY), .IMEM_RDATA(IMEM_RDATA),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .PC(PC), .PC_PLUS4(PC_PLUS4),
    .MISALIGN_TRAP(MISALIGN_TRAP), .TRAP_ADDR(TRAP_ADDR),
    .RETIRE_CNT(RETIRE_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference model: which phase the unit is in plus the architectural
  // values the spec defines for it.
  typedef enum {PH_BOOT, PH_FETCH, PH_EXEC, PH_HALT} phase_t;
  phase_t      m_ph;
  logic [31:0] m_pc, m_instr, m_taddr, m_ret;
  logic        m_trap;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] target_of(input logic [1:0] sel, input logic [31:0] pc,
                                            input logic [31:0] bt, input logic [31:0] jt);
    if (sel == 2'b01) return bt;
    if (sel == 2'b10) return jt & 32'hFFFF_FFFE;
    return pc + 32'd4;
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    if (RST) begin
      m_ph = PH_BOOT; m_pc = RV; m_instr = 32'h13;
      m_trap = 1'b0; m_taddr = 0; m_ret = 0;
    end else if (m_ph == PH_BOOT) begin
      m_ph = PH_FETCH;
    end else if (m_ph == PH_FETCH) begin
      if (IMEM_READY) begin
        m_instr = IMEM_RDATA;
        m_ph = PH_EXEC;
      end
    end else if (m_ph == PH_EXEC) begin
      if (!STALL) begin
        t = target_of(PC_Sel, m_pc, BRANCH_TARGET, JALR_TARGET);
        if (t % 4 == 0) begin
          m_pc = t; m_ret = m_ret + 1; m_ph = PH_FETCH;
        end else begin
          m_trap = 1'b1; m_taddr = t; m_ph = PH_HALT;
        end
      end
    end else begin
      if (TRAP_CLR) begin
        m_trap = 1'b0; m_pc = RV; m_ph = PH_BOOT;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_req",    IMEM_REQ,      (m_ph == PH_FETCH) ? 1 : 0);
    chk("imem_addr",   IMEM_ADDR,     m_pc);
    chk("instr_valid", INSTR_VALID,   (m_ph == PH_EXEC) ? 1 : 0);
    chk("instr",       INSTR,         m_instr);
    chk("pc",          PC,            m_pc);
    chk("pc_plus4",    PC_PLUS4,      m_pc + 32'd4);
    chk("trap",        MISALIGN_TRAP, m_trap);
    chk("trap_addr",   TRAP_ADDR,     m_taddr);
    chk("retire_cnt",  RETIRE_CNT,    m_ret);
  endtask

  task automatic step();
    IMEM_RDATA = $urandom;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input phase_t ph, input string tag);
    int k = 0;
    while (m_ph != ph && k < 20) begin
      step();
      k++;
    end
    if (m_ph != ph) chk({tag, "_timeout"}, 32'(k), 32'(0));
  endtask

  task automatic idle_inputs();
    RST = 0; PC_Sel = 2'b00; BRANCH_TARGET = 0; JALR_TARGET = 0;
    STALL = 0; TRAP_CLR = 0; IMEM_READY = 1;
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    int k;
    idle_inputs();
    IMEM_RDATA = 0;
    m_ph = PH_BOOT; m_pc = RV; m_instr = 32'h13; m_trap = 0; m_taddr = 0; m_ret = 0;

    // Reset state
    RST = 1;
    step();
    step();
    chk("rst_instr", INSTR, 32'h0000_0013);
    chk("rst_req", IMEM_REQ, 0);
    RST = 0;

    // Sequential fetch 0,4,8
    step();
    chk("seq_addr0", IMEM_ADDR, 32'h0);
    run_to(PH_EXEC, "seq0"); run_to(PH_FETCH, "seq0f");
    chk("seq_addr1", IMEM_ADDR, 32'h4);
    run_to(PH_EXEC, "seq1"); run_to(PH_FETCH, "seq1f");
    chk("seq_addr2", IMEM_ADDR, 32'h8);
    run_to(PH_EXEC, "seq2"); run_to(PH_FETCH, "seq2f");
    chk("seq_retire3", RETIRE_CNT, 32'd3);

    // Memory wait for 5 cycles
    IMEM_READY = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_req", IMEM_REQ, 1);
      chk("wait_addr", IMEM_ADDR, 32'hC);
    end
    IMEM_READY = 1;

    // Branch and JALR
    run_to(PH_EXEC, "br");
    PC_Sel = 2'b01; BRANCH_TARGET = 32'h0000_0100;
    step();
    chk("br_addr", IMEM_ADDR, 32'h100);
    PC_Sel = 2'b00;
    run_to(PH_EXEC, "jalr");
    chk("exec_pc_plus4", PC_PLUS4, 32'h104);
    PC_Sel = 2'b10; JALR_TARGET = 32'h0000_0205;
    step();
    chk("jalr_addr", IMEM_ADDR, 32'h204);
    PC_Sel = 2'b00;

    // Stall for 3 EXEC cycles
    run_to(PH_EXEC, "stall");
    held_pc = m_pc; held_instr = m_instr;
    STALL = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", PC, held_pc);
      chk("stall_instr", INSTR, held_instr);
      chk("stall_valid", INSTR_VALID, 1);
    end
    STALL = 0;
    step();

    // Misaligned trap and clear
    run_to(PH_EXEC, "trap");
    PC_Sel = 2'b01; BRANCH_TARGET = 32'h0000_0102;
    step();
    chk("trap_flag", MISALIGN_TRAP, 1);
    chk("trap_taddr", TRAP_ADDR, 32'h102);
    PC_Sel = 2'b00;
    for (int i = 0; i < 3; i++) step();
    chk("halt_req", IMEM_REQ, 0);
    TRAP_CLR = 1;
    step();
    TRAP_CLR = 0;
    step();
    chk("clr_fetch_rv", IMEM_ADDR, RV);
    chk("clr_req", IMEM_REQ, 1);

    // PC wrap at top of address space
    run_to(PH_EXEC, "wrap");
    PC_Sel = 2'b01; BRANCH_TARGET = 32'hFFFF_FFFC;
    step();
    PC_Sel = 2'b00;
    run_to(PH_EXEC, "wrap2");
    chk("wrap_pc4", PC_PLUS4, 32'h0);
    step();
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    chk("wrap_notrap", MISALIGN_TRAP, 0);

    // Reset while waiting in FETCH, with IMEM_READY in the same cycle
    IMEM_READY = 1; RST = 1;
    step();
    RST = 0;
    chk("midrst_instr", INSTR, 32'h13);
    chk("midrst_valid", INSTR_VALID, 0);
    chk("midrst_retire", RETIRE_CNT, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 99) == 0);
      PC_Sel     = 2'($urandom_range(0, 3));
      k          = $urandom_range(0, 3);
      BRANCH_TARGET = (k == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      k          = $urandom_range(0, 3);
      JALR_TARGET = (k == 0) ? ($urandom | 32'h2) : $urandom;
      STALL      = ($urandom_range(0, 3) == 0);
      TRAP_CLR   = ($urandom_range(0, 2) == 0);
      IMEM_READY = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
